// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, issue-op encoding and issue-slot layout for the register-file access controller
package regfile_pkg;
    localparam int XLEN_DEF = 32;
    localparam int AW_DEF = 5;
    typedef enum logic [1:0] {OP_NONE, OP_WR, OP_RD} op_e;
    typedef struct packed {
        op_e                 op;
        logic [AW_DEF-1:0]   dr;
        logic [AW_DEF-1:0]   sa;
        logic [AW_DEF-1:0]   sb;
        logic [XLEN_DEF-1:0] data;
    } slot_t;
endpackage

// File: rtl/regfile_grant.sv
// regfile_grant: writeback-priority arbiter with a streak limit that forces a pending read through
module regfile_grant #(
    parameter int WB_STREAK_MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic wb_valid,
    input  logic rd_valid,
    input  logic rd_busy,
    output logic wb_ready,
    output logic rd_ready,
    output logic wb_grant,
    output logic rd_grant
);
    logic [3:0] streak;
    logic rd_pend;
    logic force_rd;
    always_comb begin
        rd_pend  = rd_valid & !rd_busy;
        force_rd = rd_pend & (streak == 4'(WB_STREAK_MAX));
        wb_ready = !force_rd;
        wb_grant = wb_valid & wb_ready;
        rd_ready = !rd_busy & !wb_grant;
        rd_grant = rd_valid & rd_ready;
    end
    always_ff @(posedge CLK) begin
        if (RST || rd_grant || !rd_pend)
            streak <= '0;
        else if (wb_grant)
            streak <= streak + 4'd1;
    end
endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: shares the single LD-controlled register-file port between writeback and operand reads.
// Optional REGFILE_X0_HARDWIRE_EN: drop writes to x0 and return zero for x0 operands.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW = AW_DEF,
    parameter int WB_STREAK_MAX = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            rd_valid,
    output logic            rd_ready,
    input  logic [AW-1:0]   rd_rs1,
    input  logic [AW-1:0]   rd_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_a,
    output logic [XLEN-1:0] rsp_b,
    output logic            rf_ld,
    output logic [AW-1:0]   rf_sa,
    output logic [AW-1:0]   rf_sb,
    output logic [AW-1:0]   rf_dr,
    output logic [XLEN-1:0] rf_din,
    input  logic [XLEN-1:0] rf_data_a,
    input  logic [XLEN-1:0] rf_data_b
);
    slot_t slot;
    slot_t slot_d;
    logic rd_busy;
    logic rsp_fire;
    logic busy_eff;
    logic wb_grant;
    logic rd_grant;
    logic wr_drop;
    logic iss_rd;
    logic cap;
    logic [XLEN-1:0] cap_a;
    logic [XLEN-1:0] cap_b;

    // the read slot frees in the handshake cycle so a new read can be granted alongside it
    assign rsp_fire = rsp_valid & rsp_ready;
    assign busy_eff = rd_busy & !rsp_fire;

    regfile_grant #(.WB_STREAK_MAX(WB_STREAK_MAX)) u_grant (
        .CLK      (CLK),
        .RST      (RST),
        .wb_valid (wb_valid),
        .rd_valid (rd_valid),
        .rd_busy  (busy_eff),
        .wb_ready (wb_ready),
        .rd_ready (rd_ready),
        .wb_grant (wb_grant),
        .rd_grant (rd_grant)
    );

`ifdef REGFILE_X0_HARDWIRE_EN
    logic za;
    logic zb;
    assign wr_drop = wb_rd == '0;
    always_ff @(posedge CLK) begin
        if (RST) begin
            za <= 1'b0;
            zb <= 1'b0;
        end else begin
            za <= rf_sa == '0;
            zb <= rf_sb == '0;
        end
    end
    assign cap_a = za ? '0 : rf_data_a;
    assign cap_b = zb ? '0 : rf_data_b;
`else
    assign wr_drop = 1'b0;
    assign cap_a = rf_data_a;
    assign cap_b = rf_data_b;
`endif

    always_comb begin
        slot_d.op   = wb_grant ? (wr_drop ? OP_NONE : OP_WR) : rd_grant ? OP_RD : OP_NONE;
        slot_d.dr   = wb_rd;
        slot_d.sa   = rd_rs1;
        slot_d.sb   = rd_rs2;
        slot_d.data = wb_data;
    end

    // accept -> slot -> rf_* drive -> rf samples -> capture; iss_rd/cap track a read down that pipe
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot      <= '0;
            rf_ld     <= 1'b0;
            rf_sa     <= '0;
            rf_sb     <= '0;
            rf_dr     <= '0;
            rf_din    <= '0;
            iss_rd    <= 1'b0;
            cap       <= 1'b0;
            rd_busy   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_a     <= '0;
            rsp_b     <= '0;
        end else begin
            slot    <= slot_d;
            rf_ld   <= slot.op == OP_WR;
            rf_sa   <= slot.op == OP_RD ? slot.sa : '0;
            rf_sb   <= slot.op == OP_RD ? slot.sb : '0;
            if (slot.op == OP_WR) begin
                rf_dr  <= slot.dr;
                rf_din <= slot.data;
            end
            iss_rd  <= slot.op == OP_RD;
            cap     <= iss_rd;
            rd_busy <= rd_grant | busy_eff;
            if (cap) begin
                rsp_valid <= 1'b1;
                rsp_a     <= cap_a;
                rsp_b     <= cap_b;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed bench with a behavioural 32x32 register file behind the controller
module tb_regfile_access_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [4:0]  rd_rs1 = '0;
    logic [4:0]  rd_rs2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_a;
    logic [31:0] rsp_b;
    logic        rf_ld;
    logic [4:0]  rf_sa;
    logic [4:0]  rf_sb;
    logic [4:0]  rf_dr;
    logic [31:0] rf_din;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;
    logic [31:0] mem [32] = '{default: '0};
    int checks = 0;
    int errors = 0;

    regfile_access_ctrl dut (
        .CLK(CLK), .RST(RST),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rf_ld(rf_ld), .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_dr(rf_dr), .rf_din(rf_din),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b)
    );

    always #5 CLK = ~CLK;

    // register file: registered read when LD=0, outputs undefined on a write cycle
    always @(posedge CLK) begin
        if (rf_ld) begin
            mem[rf_dr] <= rf_din;
            rf_data_a  <= 'x;
            rf_data_b  <= 'x;
        end else begin
            rf_data_a <= mem[rf_sa];
            rf_data_b <= mem[rf_sb];
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_rd = a; wb_data = d;
        #1;
        while (!wb_ready && n < 20) begin
            step();
            #1;
            n++;
        end
        checks++;
        if (!wb_ready) begin
            errors++;
            $display("FAIL wr_grant_timeout: wb_ready=%0b, required 1", wb_ready);
        end
        step();
        wb_valid = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        int n = 0;
        rd_valid = 1'b1; rd_rs1 = a; rd_rs2 = b;
        #1;
        while (!rd_ready && n < 20) begin
            step();
            #1;
            n++;
        end
        checks++;
        if (!rd_ready) begin
            errors++;
            $display("FAIL rd_grant_timeout: rd_ready=%0b, required 1", rd_ready);
        end
        step();
        rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_a, rsp_b} !== 65'd0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%0b a=%h b=%h, required all 0", rsp_valid, rsp_a, rsp_b);
        end
        checks++;
        if ({rf_ld, rf_sa, rf_sb, rf_dr, rf_din} !== 48'd0) begin
            errors++;
            $display("FAIL reset_rf: ld=%0b sa=%0d sb=%0d dr=%0d din=%h, required all 0", rf_ld, rf_sa, rf_sb, rf_dr, rf_din);
        end
        checks++;
        if ({wb_ready, rd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: wb_ready=%0b rd_ready=%0b, required 1 1", wb_ready, rd_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_wb_ready: got %0b, required 1", wb_ready);
        end
        step();
        wb_valid = 1'b0;
        checks++;
        if (rf_ld !== 1'b0) begin
            errors++;
            $display("FAIL basic_ld_early: rf_ld=%0b, required 0", rf_ld);
        end
        step();
        checks++;
        if ({rf_ld, rf_dr, rf_din} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_issue: ld=%0b dr=%0d din=%h, required 1 5 deadbeef", rf_ld, rf_dr, rf_din);
        end
        step();
        checks++;
        if ({rf_ld, mem[5]} !== {1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_commit: ld=%0b x5=%h, required 0 deadbeef", rf_ld, mem[5]);
        end
        rd(5'd5, 5'd0);
        wait_rsp(n);
        checks++;
        if ({n, rsp_a, rsp_b} !== {32'd3, 32'hDEADBEEF, 32'd0}) begin
            errors++;
            $display("FAIL basic_read: latency=%0d a=%h b=%h, required 3 deadbeef 0", n, rsp_a, rsp_b);
        end
        consume();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_rsp_clear: rsp_valid=%0b, required 0", rsp_valid);
        end
    endtask

    task automatic test_raw();
        int n;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
        rd_valid = 1'b1; rd_rs1 = 5'd7; rd_rs2 = 5'd5;
        #1;
        checks++;
        if ({wb_ready, rd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL raw_priority: wb_ready=%0b rd_ready=%0b, required 1 0", wb_ready, rd_ready);
        end
        step();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_rd_ready: got %0b, required 1", rd_ready);
        end
        step();
        rd_valid = 1'b0;
        wait_rsp(n);
        checks++;
        if ({n, rsp_a, rsp_b} !== {32'd3, 32'h1234, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL raw_read: latency=%0d a=%h b=%h, required 3 1234 deadbeef", n, rsp_a, rsp_b);
        end
        consume();
    endtask

    task automatic test_streak();
        int n;
        logic [6:0] wg;
        logic [6:0] rg;
        wb_valid = 1'b1;
        rd_valid = 1'b1; rd_rs1 = 5'd20; rd_rs2 = 5'd23;
        for (int i = 0; i < 7; i++) begin
            wb_rd = 5'(20 + i);
            wb_data = 32'h100 + 32'(i);
            #1;
            wg[i] = wb_ready;
            rg[i] = rd_ready & rd_valid;
            step();
            if (rg[i]) rd_valid = 1'b0;
        end
        wb_valid = 1'b0;
        checks++;
        if ({wg, rg} !== {7'b1101111, 7'b0010000}) begin
            errors++;
            $display("FAIL streak_grants: wb=%b rd=%b, required 1101111 0010000", wg, rg);
        end
        wait_rsp(n);
        checks++;
        if ({rsp_a, rsp_b} !== {32'h100, 32'h103}) begin
            errors++;
            $display("FAIL streak_read: a=%h b=%h, required 100 103", rsp_a, rsp_b);
        end
        consume();
        step();
        step();
        checks++;
        if ({mem[25], mem[26]} !== {32'h105, 32'h106}) begin
            errors++;
            $display("FAIL streak_resume: x25=%h x26=%h, required 105 106", mem[25], mem[26]);
        end
    endtask

    task automatic test_hold();
        int n;
        int bad = 0;
        wr(5'd3, 32'h33);
        rd(5'd3, 5'd20);
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            wb_valid = (i < 3);
            wb_rd = 5'd3;
            wb_data = 32'hA1 + 32'(i);
            rd_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd20;
            #1;
            checks++;
            if ({rsp_valid, rd_ready, rsp_a, rsp_b, wb_ready} !== {1'b1, 1'b0, 32'h33, 32'h100, 1'b1}) begin
                errors++;
                bad++;
                $display("FAIL hold_cycle%0d: valid=%0b rd_ready=%0b a=%h b=%h wb_ready=%0b, required 1 0 33 100 1",
                         i, rsp_valid, rd_ready, rsp_a, rsp_b, wb_ready);
            end
            step();
        end
        wb_valid = 1'b0;
        checks++;
        if (mem[3] !== 32'hA3) begin
            errors++;
            $display("FAIL hold_writes: x3=%h, required a3", mem[3]);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_free: rd_ready=%0b in handshake cycle, required 1", rd_ready);
        end
        step();
        rsp_ready = 1'b0;
        rd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: rsp_valid=%0b, required 0", rsp_valid);
        end
        wait_rsp(n);
        checks++;
        if ({n, rsp_a, rsp_b} !== {32'd3, 32'hA3, 32'h100}) begin
            errors++;
            $display("FAIL hold_reread: latency=%0d a=%h b=%h, required 3 a3 100", n, rsp_a, rsp_b);
        end
        consume();
    endtask

    task automatic test_x0();
        int n;
        logic ld_seen = 1'b0;
        logic exp_ld;
        logic [31:0] exp_a;
`ifdef REGFILE_X0_HARDWIRE_EN
        exp_ld = 1'b0;
        exp_a = 32'd0;
`else
        exp_ld = 1'b1;
        exp_a = 32'hFFFF;
`endif
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        #1;
        checks++;
        if (wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_handshake: wb_ready=%0b, required 1", wb_ready);
        end
        step();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_seen |= rf_ld;
            step();
        end
        checks++;
        if (ld_seen !== exp_ld) begin
            errors++;
            $display("FAIL x0_ld: rf_ld seen=%0b, required %0b", ld_seen, exp_ld);
        end
        rd(5'd0, 5'd5);
        wait_rsp(n);
        checks++;
        if ({rsp_a, rsp_b} !== {exp_a, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL x0_read: a=%h b=%h, required %h deadbeef", rsp_a, rsp_b, exp_a);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        rd_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd5;
        #1;
        step();
        rd_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        #1;
        checks++;
        if ({wb_ready, rd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_accept: wb_ready=%0b rd_ready=%0b, required 1 0", wb_ready, rd_ready);
        end
        step();
        wb_valid = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bad |= rf_ld | rsp_valid;
            step();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: rf_ld or rsp_valid seen=%0b, required 0", bad);
        end
        checks++;
        if ({mem[9], rd_ready} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_state: x9=%h rd_ready=%0b, required 0 1", mem[9], rd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_streak();
        test_hold();
        test_x0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Sequencer/arbiter in front of the 32x32 register file, which has a single LD-controlled port. When LD=1 the port writes; when LD=0 it performs a registered two-operand read. The block shares that port between the writeback requester and the operand-read requester (decode), with in-order issue and a starvation guard. It also buffers read results, because register-file outputs go undefined on any write cycle.

Parameters:
XLEN, 32, data width
AW, 5, register address width
WB_STREAK_MAX, 4, maximum consecutive write grants while a read is pending (range 1..15)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
wb_valid  in  1  writeback request
wb_ready  out  1  writeback accepted when wb_valid & wb_ready
wb_rd  in  AW  destination register
wb_data  in  XLEN  write data
rd_valid  in  1  operand-read request
rd_ready  out  1  read accepted when rd_valid & rd_ready
rd_rs1  in  AW  source A address
rd_rs2  in  AW  source B address
rsp_valid  out  1  operand response valid
rsp_ready  in  1  response consumed
rsp_a  out  XLEN  operand A
rsp_b  out  XLEN  operand B
rf_ld  out  1  to register file LD
rf_sa  out  AW  to SA
rf_sb  out  AW  to SB
rf_dr  out  AW  to DR
rf_din  out  XLEN  to D_IN
rf_data_a  in  XLEN  from DATA_A
rf_data_b  in  XLEN  from DATA_B

Behaviour:
- All outputs are registered except wb_ready and rd_ready, which are combinational grant outputs.
- Reset (synchronous, RST=1 at an edge) clears:
  - issue slot to empty
  - capture flag to 0
  - rsp_valid, rsp_a, rsp_b to 0
  - streak counter to 0
  - rf_ld, rf_sa, rf_sb, rf_dr, rf_din to 0
- Reset mid-operation drops any in-flight read or write. No LD=1 pulse is issued in the cycle after reset.
- Pipeline: accept (edge k) -> issue cycle k+1 (rf_* driven) -> register file samples at edge k+2.
  - Write latency: the register is updated at edge k+2.
  - Read: rf_data valid during cycle k+2, captured into rsp_a/rsp_b at edge k+3, rsp_valid=1 from cycle k+3.
- Idle drive: rf_ld=0, rf_sa=rf_sb=0. Any cycle without an issued write drives rf_ld=0.
- Outstanding reads: at most one, from accept until the rsp handshake.
  - rd_ready = !read_outstanding & !wb_grant.
- Arbitration, one accept per cycle:
  - Writeback has priority.
  - If rd_valid is pending and streak == WB_STREAK_MAX, the read is granted and wb_ready=0.
  - streak increments on each write grant while rd_valid & !read_outstanding. It clears on a read grant, or on any cycle with no pending read.
  - wb_ready is also 1 while a read is outstanding; writes proceed during response hold.
- Ordering: single in-order issue. A read accepted after a write sees the new value. A write accepted after a read does not corrupt the captured response, because capture samples at edge k+3 before the write's LD edge takes effect.
- rsp_valid holds, with rsp_a/rsp_b stable, until rsp_ready. Handshake at edge clears rsp_valid and frees the read slot. rd_ready may assert in that same cycle.
- Simultaneous rd_valid & wb_valid with streak < MAX -> write granted.

Optional Feature:
REGFILE_X0_HARDWIRE_EN
- Defined:
  - A writeback with wb_rd=0 is handshaken but issues rf_ld=0 (dropped).
  - A read with rs1=0 or rs2=0 returns 0 on the corresponding rsp operand, regardless of rf_data.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF=32, AW_DEF=5
  - issue-op enum {OP_NONE, OP_WR, OP_RD}
  - issue-slot struct {op, dr, sa, sb, data}
- One sub-module: regfile_grant, the two-requester priority arbiter with streak counter. Produces wb_grant/rd_grant.

Test Plan:
- Reset with RST=1 for 2 cycles -> all outputs 0, rf_ld=0; write x5=0xDEADBEEF, then read rs1=5, rs2=0 -> rsp_a=0xDEADBEEF at cycle accept+3.
- Write x7=0x1234 accepted, read rs1=7 accepted the next cycle -> rsp_a=0x1234 (RAW ordering).
- Continuous wb_valid with rd_valid held, WB_STREAK_MAX=4 -> exactly 4 writes granted, then read granted, then writes resume.
- Hold rsp_ready=0 for 10 cycles while 3 writes to x3 complete -> rsp_a/rsp_b unchanged and rsp_valid=1 throughout; rd_ready=0 until rsp handshake.
- With REGFILE_X0_HARDWIRE_EN, write x0=0xFFFF then read rs1=0 -> wb handshake occurs, rf_ld stays 0, rsp_a=0; without the macro -> rsp_a=0xFFFF.
- Assert RST during the cycle after a write accept -> rf_ld=0 next cycle, target register unchanged, rsp_valid=0.
